// File: rtl/gyro_pkg.sv
// Shared gyro types: axis sample width, integrator state and the signed sample type used
// by the SPI master, the rate integrator and the data formatter.
package gyro_pkg;

  localparam int unsigned AXIS_W = 16;

  typedef enum logic {CAL, RUN} gyro_state_e;

  typedef logic signed [AXIS_W-1:0] gyro_sample_t;

endpackage

// File: rtl/gyro_axis_acc.sv
// One axis of the rate integrator: bias averaging, bias subtraction, deadband, angle accumulate.
// With GYRO_INT_SATURATE_EN defined the accumulator clamps and reports a sticky sat bit.
module gyro_axis_acc
  import gyro_pkg::*;
#(
  parameter int unsigned CAL_LOG2 = 4,
  parameter int unsigned DEADBAND = 8,
  parameter int unsigned ACC_W    = 32
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    cal_en,
  input  logic                    cal_last,
  input  logic                    run_en,
  input  logic                    clear,
  input  gyro_sample_t            sample,
  output gyro_sample_t            bias,
`ifdef GYRO_INT_SATURATE_EN
  output logic                    sat,
`endif
  output logic signed [ACC_W-1:0] ang
);

  localparam int unsigned SUM_W = AXIS_W + CAL_LOG2;

  logic signed [SUM_W-1:0]  sum_q, sum_next;
  gyro_sample_t             bias_q;
  logic signed [ACC_W-1:0]  ang_q, ang_next;
  logic signed [AXIS_W:0]   corr, corr_db;
  logic        [AXIS_W:0]   corr_mag;
  logic signed [ACC_W:0]    ang_sum;
`ifdef GYRO_INT_SATURATE_EN
  logic                     ovf;
  logic                     sat_q;
`endif

  always_comb begin
    sum_next = sum_q + $signed({{CAL_LOG2{sample[AXIS_W-1]}}, sample});
    corr     = $signed({sample[AXIS_W-1], sample}) - $signed({bias_q[AXIS_W-1], bias_q});
    corr_mag = corr[AXIS_W] ? $unsigned(-corr) : $unsigned(corr);
    corr_db  = (corr_mag <= (AXIS_W + 1)'(DEADBAND)) ? '0 : corr;
    // One guard bit above the accumulator exposes overflow as a sign disagreement.
    ang_sum  = $signed({ang_q[ACC_W-1], ang_q})
             + $signed({{(ACC_W - AXIS_W){corr_db[AXIS_W]}}, corr_db});
`ifdef GYRO_INT_SATURATE_EN
    ovf = ang_sum[ACC_W] != ang_sum[ACC_W-1];
    if (!ovf) begin
      ang_next = ang_sum[ACC_W-1:0];
    end else if (ang_sum[ACC_W]) begin
      ang_next = $signed({1'b1, {(ACC_W - 1){1'b0}}});
    end else begin
      ang_next = $signed({1'b0, {(ACC_W - 1){1'b1}}});
    end
`else
    ang_next = ang_sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sum_q  <= '0;
      bias_q <= '0;
      ang_q  <= '0;
`ifdef GYRO_INT_SATURATE_EN
      sat_q  <= 1'b0;
`endif
    end else if (clear) begin
      // Bias survives a recalibration request until the new average is ready.
      sum_q  <= '0;
      ang_q  <= '0;
`ifdef GYRO_INT_SATURATE_EN
      sat_q  <= 1'b0;
`endif
    end else begin
      if (cal_en) begin
        if (cal_last) begin
          bias_q <= sum_next[CAL_LOG2 +: AXIS_W];
          sum_q  <= '0;
        end else begin
          sum_q  <= sum_next;
        end
      end
      if (run_en) begin
        ang_q <= ang_next;
`ifdef GYRO_INT_SATURATE_EN
        sat_q <= sat_q | ovf;
`endif
      end
    end
  end

  assign bias = bias_q;
  assign ang  = ang_q;
`ifdef GYRO_INT_SATURATE_EN
  assign sat  = sat_q;
`endif

endmodule

// File: rtl/gyro_rate_integrator.sv
// Gyro rate integrator: start-up bias calibration then per-axis angle integration.
// Optional GYRO_INT_SATURATE_EN: saturating accumulators plus a sticky sat_flag output.
module gyro_rate_integrator
  import gyro_pkg::*;
#(
  parameter int unsigned CAL_LOG2 = 4,
  parameter int unsigned DEADBAND = 8,
  parameter int unsigned ACC_W    = 32
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    sample_valid,
  input  gyro_sample_t            x_axis_data,
  input  gyro_sample_t            y_axis_data,
  input  gyro_sample_t            z_axis_data,
  input  logic                    recal,
  output logic                    cal_done,
  output logic                    angle_valid,
  output logic signed [ACC_W-1:0] ang_x,
  output logic signed [ACC_W-1:0] ang_y,
  output logic signed [ACC_W-1:0] ang_z,
  output gyro_sample_t            bias_x,
  output gyro_sample_t            bias_y,
`ifdef GYRO_INT_SATURATE_EN
  output gyro_sample_t            bias_z,
  output logic                    sat_flag
`else
  output gyro_sample_t            bias_z
`endif
);

  gyro_state_e         state_q;
  logic [CAL_LOG2-1:0] cal_cnt_q;
  logic                cal_done_q;
  logic                angle_valid_q;
  logic                cal_en, cal_last, run_en;

  // recal takes priority: a coincident sample is neither counted nor integrated.
  assign cal_en   = sample_valid && !recal && (state_q == CAL);
  assign run_en   = sample_valid && !recal && (state_q == RUN);
  assign cal_last = cal_en && (cal_cnt_q == '1);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q       <= CAL;
      cal_cnt_q     <= '0;
      cal_done_q    <= 1'b0;
      angle_valid_q <= 1'b0;
    end else begin
      angle_valid_q <= run_en;
      if (recal) begin
        state_q    <= CAL;
        cal_cnt_q  <= '0;
        cal_done_q <= 1'b0;
      end else if (cal_en) begin
        cal_cnt_q <= cal_cnt_q + CAL_LOG2'(1);
        if (cal_last) begin
          state_q    <= RUN;
          cal_done_q <= 1'b1;
        end
      end
    end
  end

  assign cal_done    = cal_done_q;
  assign angle_valid = angle_valid_q;

`ifdef GYRO_INT_SATURATE_EN
  logic sat_x, sat_y, sat_z;
  assign sat_flag = sat_x | sat_y | sat_z;
`endif

  gyro_axis_acc #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND), .ACC_W(ACC_W)) u_acc_x (
    .clk      (clk),
    .RST      (RST),
    .cal_en   (cal_en),
    .cal_last (cal_last),
    .run_en   (run_en),
    .clear    (recal),
    .sample   (x_axis_data),
    .bias     (bias_x),
`ifdef GYRO_INT_SATURATE_EN
    .sat      (sat_x),
`endif
    .ang      (ang_x)
  );

  gyro_axis_acc #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND), .ACC_W(ACC_W)) u_acc_y (
    .clk      (clk),
    .RST      (RST),
    .cal_en   (cal_en),
    .cal_last (cal_last),
    .run_en   (run_en),
    .clear    (recal),
    .sample   (y_axis_data),
    .bias     (bias_y),
`ifdef GYRO_INT_SATURATE_EN
    .sat      (sat_y),
`endif
    .ang      (ang_y)
  );

  gyro_axis_acc #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND), .ACC_W(ACC_W)) u_acc_z (
    .clk      (clk),
    .RST      (RST),
    .cal_en   (cal_en),
    .cal_last (cal_last),
    .run_en   (run_en),
    .clear    (recal),
    .sample   (z_axis_data),
    .bias     (bias_z),
`ifdef GYRO_INT_SATURATE_EN
    .sat      (sat_z),
`endif
    .ang      (ang_z)
  );

endmodule
